alu8_seq_ctrl: RTL and testbench
================================

// Module: alu8_seq_ctrl
// PURPOSE
//  Sequential command front-end for the 8-bit combinational ALU: accepts one op via
//  valid/ready, drives registered operands/opcode into the ALU, waits a fixed settle
//  time, captures result + flags, returns them on a valid/ready response port.
//  Owns the architectural flag register {cf,ovf,sf,zf}; sits between the
//  sequencer/datapath and the ALU instance.
// PARAMETERS
//  SETTLE_CYCLES  1  ALU settle cycles between operand drive and capture; legal 1..15
// PORTS
//  clk         in   1  single clock, rising edge
//  rst         in   1  synchronous reset, active-high
//  cmd_valid   in   1  command present
//  cmd_ready   out  1  command accepted when cmd_valid & cmd_ready at posedge
//  cmd_op      in   4  ALU opcode, passed through unchanged
//  cmd_a       in   8  operand a (two's complement)
//  cmd_b       in   8  operand b; shifts use b[2:0]
//  cmd_wflags  in   1  1 = write captured flags to flag register
//  alu_a       out  8  registered operand a to ALU
//  alu_b       out  8  registered operand b to ALU
//  alu_op      out  4  registered opcode to ALU
//  alu_res     in   8  ALU result
//  alu_cf      in   1  ALU carry
//  alu_ovf     in   1  ALU overflow
//  alu_sf      in   1  ALU sign
//  alu_zf      in   1  ALU zero
//  rsp_valid   out  1  response present
//  rsp_ready   in   1  response consumed when rsp_valid & rsp_ready at posedge
//  rsp_res     out  8  captured result
//  rsp_flags   out  4  captured {cf,ovf,sf,zf} of this op (independent of cmd_wflags)
//  flags       out  4  architectural flag register {cf,ovf,sf,zf}
//  busy        out  1  1 in SETTLE or RESP
// BEHAVIOUR
//  Opcodes: 00x0 add, 00x1 sub, 0100 and, 0101 or, 0110 not(a), 0111 xor,
//   1x00 lsr, 1x01 asr, 1x1x lsl; all 16 codes legal, no decode/reject here.
//  Reset: state=IDLE, alu_a/alu_b/alu_op=0, rsp_valid=0, rsp_res=0, rsp_flags=0,
//   flags=0, settle counter=0, busy=0. cmd_ready=1 in the cycle after rst deasserts.
//  FSM IDLE -> SETTLE -> RESP -> IDLE; cmd_ready = (IDLE) | (RESP & rsp_ready).
//  IDLE: on accept, latch cmd_a/b/op -> alu_*, latch cmd_wflags,
//   counter=SETTLE_CYCLES-1, -> SETTLE.
//  SETTLE: counter!=0 -> decrement. counter==0 -> capture alu_res -> rsp_res and
//   {alu_cf,alu_ovf,alu_sf,alu_zf} -> rsp_flags; if latched wflags, same values ->
//   flags on the same edge; -> RESP.
//  RESP: rsp_valid=1, rsp_res/rsp_flags stable until handshake. Handshake with no
//   cmd_valid -> IDLE. Handshake with cmd_valid -> accept new cmd that edge, -> SETTLE
//   (back-to-back, no IDLE bubble).
//  Latency: accept at edge E -> alu_* valid after E -> capture at edge E+SETTLE_CYCLES
//   -> rsp_valid high in cycle after it; SETTLE_CYCLES=1: rsp_valid 2 cycles after accept.
//  Throughput: back-to-back, 1 op per SETTLE_CYCLES+1 cycles when rsp_ready held 1.
//  alu_* hold last command until next accept (never glitch during SETTLE/RESP).
//  flags changes only at a capture edge with wflags=1, or rst.
//  Reset mid-op (SETTLE or RESP): in-flight op dropped, no response, all reset values.
//  cmd_* ignored when cmd_ready=0; rsp_ready ignored when rsp_valid=0.
// TESTING (bench instantiates the real ALU on alu_* ports)
//  add op=0000 a=7F b=01 wflags=1 -> rsp_res=80, rsp_flags=0110, flags=0110, 2 cyc.
//  sub op=0001 a=05 b=05 wflags=1 -> rsp_res=00, rsp_flags=1001, flags=1001.
//  asr op=1001 a=80 b=02 wflags=0 -> rsp_res=E0, rsp_flags=0010, flags keeps 1001.
//  rsp_ready=0 for 5 cycles -> rsp_valid/rsp_res stable, cmd_ready=0, alu_* unchanged.
//  rsp_ready=1, 3 cmds back-to-back -> responses in order, 1 op per 2 cycles.
//  SETTLE_CYCLES=4, rst in 2nd SETTLE cycle -> no rsp_valid, flags=0, cmd_ready=1 next.

Source files
------------

// File: rtl/alu8_seq_ctrl_if.sv
// Command / ALU / response signal bundle for the ALU sequencing front-end.
// slave = the controller side, master = sequencer + ALU side.
interface alu8_seq_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       cmd_wflags;

    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_op;
    logic [7:0] alu_res;
    logic       alu_cf;
    logic       alu_ovf;
    logic       alu_sf;
    logic       alu_zf;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_res;
    logic [3:0] rsp_flags;
    logic [3:0] flags;
    logic       busy;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_wflags,
        input  alu_res, alu_cf, alu_ovf, alu_sf, alu_zf,
        input  rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_op,
        output rsp_valid, rsp_res, rsp_flags, flags, busy
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_wflags,
        output alu_res, alu_cf, alu_ovf, alu_sf, alu_zf,
        output rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_op,
        input  rsp_valid, rsp_res, rsp_flags, flags, busy
    );
endinterface

// File: rtl/alu8_seq_ctrl.sv
// Sequential front-end for the 8-bit combinational ALU: one op in flight,
// registered operands, fixed settle delay, captured result/flags returned on
// a valid/ready response port. Owns the architectural {cf,ovf,sf,zf} register.
module alu8_seq_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1   // legal 1..15
) (
    input  logic          clk,
    input  logic          rst,
    alu8_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, RESP = 2'd2} state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       wflags_q;
    logic       accept;

    // A new command can land while the previous response is being consumed,
    // so RESP hands straight over to SETTLE without an IDLE bubble.
    assign bus.cmd_ready = (state == IDLE) || ((state == RESP) && bus.rsp_ready);
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign bus.rsp_valid = (state == RESP);
    assign bus.busy      = (state != IDLE);

    // Sequencer FSM, operand/opcode registers, capture and flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            wflags_q      <= 1'b0;
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            bus.alu_op    <= '0;
            bus.rsp_res   <= '0;
            bus.rsp_flags <= '0;
            bus.flags     <= '0;
        end else begin
            case (state)
                IDLE: ;
                SETTLE: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        bus.rsp_res   <= bus.alu_res;
                        bus.rsp_flags <= {bus.alu_cf, bus.alu_ovf, bus.alu_sf, bus.alu_zf};
                        if (wflags_q)
                            bus.flags <= {bus.alu_cf, bus.alu_ovf, bus.alu_sf, bus.alu_zf};
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // Accept overrides the RESP->IDLE move above for back-to-back ops.
            if (accept) begin
                bus.alu_a  <= bus.cmd_a;
                bus.alu_b  <= bus.cmd_b;
                bus.alu_op <= bus.cmd_op;
                wflags_q   <= bus.cmd_wflags;
                cnt        <= CNT_INIT;
                state      <= SETTLE;
            end
        end
    end
endmodule

// File: tb/tb_alu8_seq_ctrl.sv
// Bench for alu8_seq_ctrl: behavioural ALU on the alu_* ports, vector table,
// hand sequences for stall / back-to-back / mid-op reset, and a randomized
// stream checked against a queue-based reference model.
module tb_alu8_seq_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [3:0] mflags;

    alu8_seq_ctrl_if b0();
    alu8_seq_ctrl_if b1();

    alu8_seq_ctrl #(.SETTLE_CYCLES(1)) dut0 (.clk(clk), .rst(rst0), .bus(b0));
    alu8_seq_ctrl #(.SETTLE_CYCLES(4)) dut1 (.clk(clk), .rst(rst1), .bus(b1));

    always @(posedge clk) cyc <= cyc + 1;

    // Reference ALU: {res, cf, ovf, sf, zf}
    function automatic logic [11:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        logic [7:0] r;
        logic       cf, ovf;
        cf = 1'b0; ovf = 1'b0; s = '0;
        casez (op)
            4'b00?0: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; cf = s[8];
                           ovf = (a[7] == b[7]) && (r[7] != a[7]); end
            4'b00?1: begin s = {1'b0, a} + {1'b0, ~b} + 9'd1; r = s[7:0]; cf = s[8];
                           ovf = (a[7] != b[7]) && (r[7] != a[7]); end
            4'b0100: r = a & b;
            4'b0101: r = a | b;
            4'b0110: r = ~a;
            4'b0111: r = a ^ b;
            4'b1?00: r = a >> b[2:0];
            4'b1?01: r = $signed(a) >>> b[2:0];
            default: r = a << b[2:0];
        endcase
        return {r, cf, ovf, r[7], (r == 8'd0)};
    endfunction

    assign {b0.alu_res, b0.alu_cf, b0.alu_ovf, b0.alu_sf, b0.alu_zf} = alu_f(b0.alu_op, b0.alu_a, b0.alu_b);
    assign {b1.alu_res, b1.alu_cf, b1.alu_ovf, b1.alu_sf, b1.alu_zf} = alu_f(b1.alu_op, b1.alu_a, b1.alu_b);

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       wf;
        logic [7:0] res;
        logic [3:0] rf;
        logic [3:0] fl;
    } vec_t;

    typedef struct packed {
        logic [7:0] res;
        logic [3:0] fl;
        logic       wf;
        int         due;
    } exp_t;

    vec_t vt [13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Streams commands into dut0; rnd=0 means cmd_valid/rsp_ready held high.
    task automatic run_stream(input int ncmd, input bit rnd, input int maxcyc);
        exp_t q[$];
        exp_t h;
        logic [11:0] m;
        int sent = 0;
        int last_hs = -1;
        int c0 = cyc;
        bit seen = 1'b0;
        while ((sent < ncmd || q.size() != 0) && (cyc - c0) < maxcyc) begin
            b0.cmd_valid  = (sent < ncmd) ? (rnd ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
            b0.cmd_op     = 4'($urandom);
            b0.cmd_a      = 8'($urandom);
            b0.cmd_b      = 8'($urandom);
            b0.cmd_wflags = 1'($urandom);
            b0.rsp_ready  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (b0.rsp_valid) begin
                if (q.size() == 0) begin
                    chk("rsp_unexpected", 32'(b0.rsp_valid), 32'd0);
                end else begin
                    h = q[0];
                    if (!seen) begin
                        chk("rsp_latency", 32'(cyc), 32'(h.due));
                        seen = 1'b1;
                    end
                    if (b0.rsp_ready) begin
                        chk("stream_res", 32'(b0.rsp_res), 32'(h.res));
                        chk("stream_rflags", 32'(b0.rsp_flags), 32'(h.fl));
                        if (h.wf) mflags = h.fl;
                        chk("stream_flags", 32'(b0.flags), 32'(mflags));
                        if (!rnd && last_hs >= 0) chk("b2b_spacing", 32'(cyc - last_hs), 32'd2);
                        last_hs = cyc;
                        void'(q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
            if (b0.cmd_valid && b0.cmd_ready) begin
                m = alu_f(b0.cmd_op, b0.cmd_a, b0.cmd_b);
                h.res = m[11:4]; h.fl = m[3:0]; h.wf = b0.cmd_wflags; h.due = cyc + 2;
                q.push_back(h);
                sent++;
            end
            tick();
        end
        chk("stream_done", 32'(q.size() + (ncmd - sent)), 32'd0);
        b0.cmd_valid = 1'b0;
        b0.rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = {4'b0000, 8'h7F, 8'h01, 1'b1, 8'h80, 4'b0110, 4'b0110};
        vt[1]  = {4'b0001, 8'h05, 8'h05, 1'b1, 8'h00, 4'b1001, 4'b1001};
        vt[2]  = {4'b1001, 8'h80, 8'h02, 1'b0, 8'hE0, 4'b0010, 4'b1001};
        vt[3]  = {4'b0010, 8'hFF, 8'h02, 1'b1, 8'h01, 4'b1000, 4'b1000};
        vt[4]  = {4'b0011, 8'h00, 8'h01, 1'b1, 8'hFF, 4'b0010, 4'b0010};
        vt[5]  = {4'b0100, 8'hF0, 8'h3C, 1'b1, 8'h30, 4'b0000, 4'b0000};
        vt[6]  = {4'b0101, 8'h0F, 8'h80, 1'b0, 8'h8F, 4'b0010, 4'b0000};
        vt[7]  = {4'b0110, 8'h55, 8'hAA, 1'b1, 8'hAA, 4'b0010, 4'b0010};
        vt[8]  = {4'b0111, 8'hFF, 8'hFF, 1'b1, 8'h00, 4'b0001, 4'b0001};
        vt[9]  = {4'b1100, 8'h80, 8'h0F, 1'b1, 8'h01, 4'b0000, 4'b0000};
        vt[10] = {4'b1010, 8'h81, 8'h01, 1'b0, 8'h02, 4'b0000, 4'b0000};
        vt[11] = {4'b1111, 8'h01, 8'hFF, 1'b1, 8'h80, 4'b0010, 4'b0010};
        vt[12] = {4'b0001, 8'h80, 8'h01, 1'b1, 8'h7F, 4'b1100, 4'b1100};

        rst0 = 1'b1; rst1 = 1'b1;
        b0.cmd_valid = 1'b0; b0.cmd_op = '0; b0.cmd_a = '0; b0.cmd_b = '0;
        b0.cmd_wflags = 1'b0; b0.rsp_ready = 1'b0;
        b1.cmd_valid = 1'b0; b1.cmd_op = '0; b1.cmd_a = '0; b1.cmd_b = '0;
        b1.cmd_wflags = 1'b0; b1.rsp_ready = 1'b0;
        repeat (3) tick();
        chk("rst_alu", 32'({b0.alu_a, b0.alu_b, b0.alu_op}), 32'd0);
        chk("rst_rsp", 32'({b0.rsp_valid, b0.rsp_res, b0.rsp_flags}), 32'd0);
        chk("rst_flags_busy", 32'({b0.flags, b0.busy}), 32'd0);
        rst0 = 1'b0; rst1 = 1'b0;
        tick();
        chk("rst_cmd_ready", 32'(b0.cmd_ready), 32'd1);

        // Vector table, one op at a time, SETTLE_CYCLES=1
        for (int i = 0; i < 13; i++) begin
            b0.cmd_op = vt[i].op; b0.cmd_a = vt[i].a; b0.cmd_b = vt[i].b;
            b0.cmd_wflags = vt[i].wf; b0.cmd_valid = 1'b1;
            #1;
            chk($sformatf("v%0d_ready", i), 32'(b0.cmd_ready), 32'd1);
            tick();
            b0.cmd_valid = 1'b0;
            chk($sformatf("v%0d_settle", i), 32'({b0.rsp_valid, b0.busy}), 32'b01);
            chk($sformatf("v%0d_alu", i), 32'({b0.alu_op, b0.alu_a, b0.alu_b}), 32'({vt[i].op, vt[i].a, vt[i].b}));
            tick();
            chk($sformatf("v%0d_valid", i), 32'(b0.rsp_valid), 32'd1);
            chk($sformatf("v%0d_res", i), 32'(b0.rsp_res), 32'(vt[i].res));
            chk($sformatf("v%0d_rflags", i), 32'(b0.rsp_flags), 32'(vt[i].rf));
            chk($sformatf("v%0d_flags", i), 32'(b0.flags), 32'(vt[i].fl));
            b0.rsp_ready = 1'b1;
            tick();
            b0.rsp_ready = 1'b0;
            chk($sformatf("v%0d_idle", i), 32'({b0.rsp_valid, b0.busy}), 32'd0);
        end

        // Response stall: output held, new command refused, operands frozen
        b0.cmd_op = 4'b0000; b0.cmd_a = 8'h10; b0.cmd_b = 8'h20; b0.cmd_wflags = 1'b0;
        b0.cmd_valid = 1'b1;
        tick();
        b0.cmd_a = 8'hAA; b0.cmd_b = 8'h55;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall%0d", k),
                32'({b0.rsp_valid, b0.rsp_res, b0.cmd_ready, b0.alu_a, b0.alu_b}),
                32'({1'b1, 8'h30, 1'b0, 8'h10, 8'h20}));
            tick();
        end
        b0.cmd_valid = 1'b0; b0.rsp_ready = 1'b1;
        tick();
        b0.rsp_ready = 1'b0;
        chk("stall_release", 32'({b0.rsp_valid, b0.alu_a}), 32'({1'b0, 8'h10}));

        // Back-to-back throughput then random stream, from a clean flag register
        rst0 = 1'b1; tick(); rst0 = 1'b0; mflags = 4'd0;
        run_stream(3, 1'b0, 50);
        run_stream(150, 1'b1, 3000);

        // SETTLE_CYCLES=4: latency, then reset in the 2nd SETTLE cycle
        b1.cmd_op = 4'b0000; b1.cmd_a = 8'h7F; b1.cmd_b = 8'h01; b1.cmd_wflags = 1'b1;
        b1.cmd_valid = 1'b1;
        tick();
        b1.cmd_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("s4_wait%0d", k), 32'({b1.rsp_valid, b1.busy}), 32'b01);
            tick();
        end
        chk("s4_rsp", 32'({b1.rsp_valid, b1.rsp_res, b1.rsp_flags, b1.flags}),
            32'({1'b1, 8'h80, 4'b0110, 4'b0110}));
        b1.rsp_ready = 1'b1;
        tick();
        b1.rsp_ready = 1'b0;
        b1.cmd_op = 4'b0001; b1.cmd_a = 8'h05; b1.cmd_b = 8'h05; b1.cmd_valid = 1'b1;
        tick();
        b1.cmd_valid = 1'b0;
        tick();
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        chk("s4_rst_state", 32'({b1.rsp_valid, b1.busy, b1.cmd_ready}), 32'b001);
        chk("s4_rst_regs", 32'({b1.flags, b1.rsp_res, b1.rsp_flags, b1.alu_a}), 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("s4_norsp%0d", k), 32'({b1.rsp_valid, b1.flags}), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
